// File: rtl/ysyx_23060221_axi_pkg.sv
// ysyx_23060221_axi_pkg: grant/state encodings and AXI response codes shared by the arbiter slice
package ysyx_23060221_axi_pkg;
    localparam logic [1:0] GNT_NONE   = 2'd0;
    localparam logic [1:0] GNT_IFU_RD = 2'd1;
    localparam logic [1:0] GNT_LSU_RD = 2'd2;
    localparam logic [1:0] GNT_LSU_WR = 2'd3;
    localparam logic [1:0] OKAY       = 2'b00;
    localparam logic [1:0] SLVERR     = 2'b10;
    localparam logic [1:0] DECERR     = 2'b11;
endpackage

// File: rtl/ysyx_23060221_axi_arbiter_if.sv
// ysyx_23060221_axi_arbiter_if: one AXI4 port (AR/R/AW/W/B) with master and slave modports
interface ysyx_23060221_axi_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              arvalid, arready;
    logic [ADDR_W-1:0] araddr;
    logic [3:0]        arid;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              rvalid, rready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic [3:0]        rid;
    logic              awvalid, awready;
    logic [ADDR_W-1:0] awaddr;
    logic [3:0]        awid;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              wvalid, wready;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic              wlast;
    logic              bvalid, bready;
    logic [1:0]        bresp;
    logic [3:0]        bid;
    modport master (
        output arvalid, araddr, arid, arlen, arsize, arburst, input arready,
        input rvalid, rdata, rresp, rlast, rid, output rready,
        output awvalid, awaddr, awid, awlen, awsize, awburst, input awready,
        output wvalid, wdata, wstrb, wlast, input wready,
        input bvalid, bresp, bid, output bready
    );
    modport slave (
        input arvalid, araddr, arid, arlen, arsize, arburst, output arready,
        output rvalid, rdata, rresp, rlast, rid, input rready,
        input awvalid, awaddr, awid, awlen, awsize, awburst, output awready,
        input wvalid, wdata, wstrb, wlast, output wready,
        output bvalid, bresp, bid, input bready
    );
endinterface

// File: rtl/ysyx_23060221_arb_pick.sv
// ysyx_23060221_arb_pick: IDLE-cycle winner selection; fixed lsu_aw > lsu_ar > ifu_ar, or IFU/LSU round-robin under ARB_RR_EN
module ysyx_23060221_arb_pick
    import ysyx_23060221_axi_pkg::*;
(
    input  logic       i_ifu_ar,
    input  logic       i_lsu_ar,
    input  logic       i_lsu_aw,
`ifdef ARB_RR_EN
    input  logic       i_lsu_pref,
`endif
    output logic [1:0] o_gnt
);
    logic [1:0] w_lsu;
    // LSU candidate: a write beats a read inside the LSU class
    always_comb w_lsu = i_lsu_aw ? GNT_LSU_WR : i_lsu_ar ? GNT_LSU_RD : GNT_NONE;
`ifdef ARB_RR_EN
    // IFU wins unless the pointer favours LSU and LSU is actually requesting
    always_comb o_gnt = (i_ifu_ar && !(i_lsu_pref && w_lsu != GNT_NONE)) ? GNT_IFU_RD : w_lsu;
`else
    // any LSU request outranks the IFU
    always_comb o_gnt = w_lsu != GNT_NONE ? w_lsu : i_ifu_ar ? GNT_IFU_RD : GNT_NONE;
`endif
endmodule

// File: rtl/ysyx_23060221_axi_arbiter.sv
// ysyx_23060221_axi_arbiter: IFU/LSU to single AXI master arbiter; ARB_RR_EN selects round-robin instead of fixed priority
module ysyx_23060221_axi_arbiter
    import ysyx_23060221_axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
)(
    input  logic       clk,
    input  logic       rst,
    ysyx_23060221_axi_arbiter_if.slave  ifu,
    ysyx_23060221_axi_arbiter_if.slave  lsu,
    ysyx_23060221_axi_arbiter_if.master m,
    output logic [1:0] grant_o
);
    logic [1:0]        r_gnt, w_pick, w_nxt;
    logic              w_ifu_rd, w_lsu_rd, w_lsu_wr, w_rdone, w_bdone, w_unused;
    logic [ADDR_W-1:0] w_araddr;
    logic [DATA_W-1:0] w_wdata;
`ifdef ARB_RR_EN
    logic              r_lsu_pref;
`endif

    ysyx_23060221_arb_pick u_pick (
        .i_ifu_ar   (ifu.arvalid),
        .i_lsu_ar   (lsu.arvalid),
        .i_lsu_aw   (lsu.awvalid),
`ifdef ARB_RR_EN
        .i_lsu_pref (r_lsu_pref),
`endif
        .o_gnt      (w_pick)
    );

    assign w_ifu_rd = r_gnt == GNT_IFU_RD;
    assign w_lsu_rd = r_gnt == GNT_LSU_RD;
    assign w_lsu_wr = r_gnt == GNT_LSU_WR;
    assign w_rdone  = m.rvalid & m.rready & m.rlast;
    assign w_bdone  = m.bvalid & m.bready;
    assign grant_o  = r_gnt;

    // next owner: pick only from IDLE, release straight to IDLE on the final handshake
    always_comb w_nxt = r_gnt == GNT_NONE ? w_pick : (w_lsu_wr ? w_bdone : w_rdone) ? GNT_NONE : r_gnt;

    // grant register doubles as the FSM state
    always_ff @(posedge clk) begin
        if (rst) r_gnt <= GNT_NONE;
        else     r_gnt <= w_nxt;
    end

`ifdef ARB_RR_EN
    // remember which class won last so the other one is preferred next time
    always_ff @(posedge clk) begin
        if (rst)                                         r_lsu_pref <= 1'b0;
        else if (r_gnt == GNT_NONE && w_pick != GNT_NONE) r_lsu_pref <= w_pick == GNT_IFU_RD;
    end
`endif

    assign w_araddr  = w_lsu_rd ? lsu.araddr : ifu.araddr;
    assign m.arvalid = (w_ifu_rd & ifu.arvalid) | (w_lsu_rd & lsu.arvalid);
    assign m.araddr  = w_araddr;
    assign m.arid    = w_lsu_rd ? lsu.arid    : ifu.arid;
    assign m.arlen   = w_lsu_rd ? lsu.arlen   : ifu.arlen;
    assign m.arsize  = w_lsu_rd ? lsu.arsize  : ifu.arsize;
    assign m.arburst = w_lsu_rd ? lsu.arburst : ifu.arburst;
    assign ifu.arready = w_ifu_rd & m.arready;
    assign lsu.arready = w_lsu_rd & m.arready;

    assign m.rready  = (w_ifu_rd & ifu.rready) | (w_lsu_rd & lsu.rready);
    assign ifu.rvalid = w_ifu_rd & m.rvalid;
    assign lsu.rvalid = w_lsu_rd & m.rvalid;
    assign ifu.rdata = m.rdata;
    assign ifu.rresp = m.rresp;
    assign ifu.rlast = m.rlast;
    assign ifu.rid   = m.rid;
    assign lsu.rdata = m.rdata;
    assign lsu.rresp = m.rresp;
    assign lsu.rlast = m.rlast;
    assign lsu.rid   = m.rid;

    assign w_wdata   = lsu.wdata;
    assign m.awvalid = w_lsu_wr & lsu.awvalid;
    assign m.awaddr  = lsu.awaddr;
    assign m.awid    = lsu.awid;
    assign m.awlen   = lsu.awlen;
    assign m.awsize  = lsu.awsize;
    assign m.awburst = lsu.awburst;
    assign lsu.awready = w_lsu_wr & m.awready;
    assign m.wvalid  = w_lsu_wr & lsu.wvalid;
    assign m.wdata   = w_wdata;
    assign m.wstrb   = lsu.wstrb;
    assign m.wlast   = lsu.wlast;
    assign lsu.wready = w_lsu_wr & m.wready;
    assign m.bready  = w_lsu_wr & lsu.bready;
    assign lsu.bvalid = w_lsu_wr & m.bvalid;
    assign lsu.bresp = m.bresp;
    assign lsu.bid   = m.bid;

    // the IFU never writes
    assign ifu.awready = 1'b0;
    assign ifu.wready  = 1'b0;
    assign ifu.bvalid  = 1'b0;
    assign ifu.bresp   = OKAY;
    assign ifu.bid     = 4'd0;
    assign w_unused = &{1'b0, ifu.awvalid, ifu.awaddr, ifu.awid, ifu.awlen, ifu.awsize, ifu.awburst,
                        ifu.wvalid, ifu.wdata, ifu.wstrb, ifu.wlast, ifu.bready};
endmodule

// File: tb/tb_ysyx_23060221_axi_arbiter.sv
// tb_ysyx_23060221_axi_arbiter: scoreboard bench with IFU/LSU master agents and a downstream AXI slave model
module tb_ysyx_23060221_axi_arbiter;
    import ysyx_23060221_axi_pkg::*;

    typedef struct {logic [31:0] addr; logic [7:0] len;} rreq_t;
    typedef struct {logic [31:0] data; logic [1:0] resp; logic last;} rbeat_t;
    typedef struct {logic [31:0] addr; logic [31:0] data; logic [3:0] strb;} wreq_t;

    logic clk = 1'b0, rst = 1'b1;
    logic [1:0] grant_o;
    always #5 clk = ~clk;

    ysyx_23060221_axi_arbiter_if ifu();
    ysyx_23060221_axi_arbiter_if lsu();
    ysyx_23060221_axi_arbiter_if m();

    ysyx_23060221_axi_arbiter dut (.clk(clk), .rst(rst), .ifu(ifu), .lsu(lsu), .m(m), .grant_o(grant_o));

    int errs = 0, checks = 0;
    rreq_t  q_ifu_req[$], q_lsu_req[$];
    wreq_t  q_wreq[$], q_wr[$];
    rbeat_t q_ifu_r[$], q_lsu_r[$];
    logic [1:0] q_gnt[$], q_b[$];
    logic [1:0] cfg_rresp = OKAY, cfg_bresp = OKAY;
    logic i_busy, l_busy, w_busy;
    logic s_rbusy, s_gaw, s_gw;
    logic [31:0] s_raddr, s_awaddr, s_wdata, s_maddr;
    logic [7:0] s_rlen, s_beat;
    logic [3:0] s_rid, s_awid, s_wstrb;
    int s_bcnt, lr_cnt;
    logic [1:0] s_gnt, g_prev = 2'd0;
    logic s_iarready;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] rd_val(input logic [31:0] a, input logic [7:0] b);
        return (a + {22'd0, b, 2'b00}) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [11:0] outs();
        return {m.arvalid, m.awvalid, m.wvalid, m.rready, m.bready, ifu.arready, ifu.rvalid,
                lsu.arready, lsu.awready, lsu.wready, lsu.rvalid, lsu.bvalid};
    endfunction

    task automatic step();
        logic f_iar, f_ir, f_lar, f_lr, f_law, f_lw, f_lb, f_mar, f_mr, f_maw, f_mw, f_mb, ir_last, lr_last, mr_last;
        logic [31:0] m_araddr;
        logic [7:0] m_arlen;
        logic [3:0] m_arid;
        rbeat_t e;
        rreq_t r;
        wreq_t w, we;
        logic [1:0] eb;
        @(negedge clk);
        s_gnt = grant_o;
        s_iarready = ifu.arready;
        s_maddr = m.araddr;
        f_iar = ifu.arvalid & ifu.arready;
        f_ir  = ifu.rvalid & ifu.rready;
        f_lar = lsu.arvalid & lsu.arready;
        f_lr  = lsu.rvalid & lsu.rready;
        f_law = lsu.awvalid & lsu.awready;
        f_lw  = lsu.wvalid & lsu.wready;
        f_lb  = lsu.bvalid & lsu.bready;
        f_mar = m.arvalid & m.arready;
        f_mr  = m.rvalid & m.rready;
        f_maw = m.awvalid & m.awready;
        f_mw  = m.wvalid & m.wready;
        f_mb  = m.bvalid & m.bready;
        ir_last = ifu.rlast;
        lr_last = lsu.rlast;
        mr_last = m.rlast;
        m_araddr = m.araddr;
        m_arlen = m.arlen;
        m_arid = m.arid;
        if (s_gnt !== g_prev) begin
            chk("gnt_seq", s_gnt, q_gnt.size() ? q_gnt.pop_front() : 2'bxx);
            g_prev = s_gnt;
        end
        if (f_ir) begin
            e = q_ifu_r.size() ? q_ifu_r.pop_front() : '{32'hx, 2'bx, 1'bx};
            chk("ifu_r", {ifu.rresp, ifu.rlast, ifu.rdata}, {e.resp, e.last, e.data});
        end
        if (f_lr) begin
            lr_cnt++;
            e = q_lsu_r.size() ? q_lsu_r.pop_front() : '{32'hx, 2'bx, 1'bx};
            chk("lsu_r", {lsu.rresp, lsu.rlast, lsu.rdata}, {e.resp, e.last, e.data});
        end
        if (f_lb) begin
            eb = q_b.size() ? q_b.pop_front() : 2'bxx;
            chk("lsu_b", lsu.bresp, eb);
        end
        if (f_maw) begin s_awaddr = m.awaddr; s_awid = m.awid; end
        if (f_mw) begin s_wdata = m.wdata; s_wstrb = m.wstrb; end
        if (f_mb) begin
            we = q_wr.size() ? q_wr.pop_front() : '{32'hx, 32'hx, 4'hx};
            chk("m_write", {s_awaddr, s_wdata, s_wstrb}, {we.addr, we.data, we.strb});
        end
        @(posedge clk);
        #1;
        if (rst) begin
            i_busy = 0; l_busy = 0; w_busy = 0; s_rbusy = 0; s_gaw = 0; s_gw = 0; s_bcnt = 0; s_beat = 0; s_rlen = 0;
            s_raddr = 0; s_rid = 0; s_awid = 0;
            q_ifu_r.delete(); q_lsu_r.delete(); q_wr.delete(); q_b.delete();
            ifu.arvalid = 0; ifu.rready = 0; ifu.awvalid = 0; ifu.wvalid = 0; ifu.bready = 0;
            ifu.araddr = 0; ifu.arid = 4'h1; ifu.arlen = 0; ifu.arsize = 3'd2; ifu.arburst = 2'b01;
            ifu.awaddr = 0; ifu.awid = 0; ifu.awlen = 0; ifu.awsize = 0; ifu.awburst = 0;
            ifu.wdata = 0; ifu.wstrb = 0; ifu.wlast = 0;
            lsu.arvalid = 0; lsu.rready = 0; lsu.awvalid = 0; lsu.wvalid = 0; lsu.bready = 0;
            lsu.araddr = 0; lsu.arid = 4'h2; lsu.arlen = 0; lsu.arsize = 3'd2; lsu.arburst = 2'b01;
            lsu.awaddr = 0; lsu.awid = 4'h3; lsu.awlen = 0; lsu.awsize = 3'd2; lsu.awburst = 2'b01;
            lsu.wdata = 0; lsu.wstrb = 0; lsu.wlast = 0;
        end else begin
            ifu.rready = 1; lsu.rready = 1; lsu.bready = 1;
            if (f_iar) begin ifu.arvalid = 0; i_busy = 1; end
            if (f_ir && ir_last) i_busy = 0;
            if (!ifu.arvalid && !i_busy && q_ifu_req.size() != 0) begin
                r = q_ifu_req.pop_front();
                ifu.arvalid = 1; ifu.araddr = r.addr; ifu.arlen = r.len;
                for (int b = 0; b <= int'(r.len); b++) q_ifu_r.push_back('{rd_val(r.addr, 8'(b)), cfg_rresp, b == int'(r.len)});
            end
            if (f_lar) begin lsu.arvalid = 0; l_busy = 1; end
            if (f_lr && lr_last) l_busy = 0;
            if (!lsu.arvalid && !l_busy && q_lsu_req.size() != 0) begin
                r = q_lsu_req.pop_front();
                lsu.arvalid = 1; lsu.araddr = r.addr; lsu.arlen = r.len;
                for (int b = 0; b <= int'(r.len); b++) q_lsu_r.push_back('{rd_val(r.addr, 8'(b)), cfg_rresp, b == int'(r.len)});
            end
            if (f_law) lsu.awvalid = 0;
            if (f_lw) lsu.wvalid = 0;
            if (f_lb) w_busy = 0;
            if (!w_busy && q_wreq.size() != 0) begin
                w = q_wreq.pop_front();
                w_busy = 1; lsu.awvalid = 1; lsu.wvalid = 1; lsu.wlast = 1;
                lsu.awaddr = w.addr; lsu.wdata = w.data; lsu.wstrb = w.strb;
                q_wr.push_back(w); q_b.push_back(cfg_bresp);
            end
            if (f_mar) begin s_rbusy = 1; s_raddr = m_araddr; s_rlen = m_arlen; s_rid = m_arid; s_beat = 0; end
            else if (f_mr) begin
                if (mr_last) s_rbusy = 0;
                else s_beat++;
            end
            if (f_maw) s_gaw = 1;
            if (f_mw) s_gw = 1;
            if (f_mb) begin s_gaw = 0; s_gw = 0; s_bcnt = 0; end
            if (s_gaw && s_gw && s_bcnt < 3) s_bcnt++;
        end
        m.arready = !s_rbusy;
        m.rvalid = s_rbusy;
        m.rdata = rd_val(s_raddr, s_beat);
        m.rlast = s_beat == s_rlen;
        m.rresp = cfg_rresp;
        m.rid = s_rid;
        m.awready = !s_gaw;
        m.wready = !s_gw;
        m.bvalid = s_gaw && s_gw && s_bcnt == 3;
        m.bresp = cfg_bresp;
        m.bid = s_awid;
    endtask

    task automatic wait_gnt(input logic [1:0] g, output int n);
        n = 0;
        do begin step(); n++; end while (s_gnt !== g && n < 200);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, cnt;
        logic blk;
        repeat (3) step();
        chk("rst_gnt", grant_o, GNT_NONE);
        chk("rst_outs", outs(), 12'd0);
        rst = 0;
        step();

        // lone IFU read: registered grant, address routed, released after rlast
        q_gnt.push_back(GNT_IFU_RD); q_gnt.push_back(GNT_NONE);
        q_ifu_req.push_back('{32'h3000_0000, 8'd0});
        step();
        wait_gnt(GNT_IFU_RD, n);
        chk("ifu_lat", n, 2);
        chk("ifu_maddr", s_maddr, 32'h3000_0000);
        wait_gnt(GNT_NONE, n);
        chk("ifu_rel", n, 2);

        // simultaneous IFU and LSU reads: LSU first, IFU one IDLE cycle after rlast
        q_gnt.push_back(GNT_LSU_RD); q_gnt.push_back(GNT_NONE); q_gnt.push_back(GNT_IFU_RD); q_gnt.push_back(GNT_NONE);
        q_lsu_req.push_back('{32'h8000_0040, 8'd1});
        q_ifu_req.push_back('{32'h3000_0100, 8'd0});
        step();
        wait_gnt(GNT_LSU_RD, n);
        chk("both_lat", n, 2);
        wait_gnt(GNT_NONE, n);
        wait_gnt(GNT_IFU_RD, n);
        chk("both_turn", n, 1);
        wait_gnt(GNT_NONE, n);

        // LSU write with SLVERR, IFU held off until the write response
        cfg_bresp = SLVERR;
        q_gnt.push_back(GNT_LSU_WR); q_gnt.push_back(GNT_NONE); q_gnt.push_back(GNT_IFU_RD); q_gnt.push_back(GNT_NONE);
        q_wreq.push_back('{32'h8000_1000, 32'hDEAD_BEEF, 4'hF});
        step();
        q_ifu_req.push_back('{32'h3000_0200, 8'd0});
        step();
        wait_gnt(GNT_LSU_WR, n);
        chk("wr_lat", n, 1);
        blk = 0; cnt = 0;
        while (s_gnt == GNT_LSU_WR && cnt < 100) begin blk |= s_iarready; step(); cnt++; end
        chk("wr_ifu_blocked", blk, 1'b0);
        chk("wr_hold", cnt >= 4, 1'b1);
        wait_gnt(GNT_IFU_RD, n);
        chk("wr_turn", n, 1);
        wait_gnt(GNT_NONE, n);
        cfg_bresp = OKAY;

        // DECERR on a 3-beat IFU read: passed through, normal release
        cfg_rresp = DECERR;
        q_gnt.push_back(GNT_IFU_RD); q_gnt.push_back(GNT_NONE);
        q_ifu_req.push_back('{32'h3000_0300, 8'd2});
        step();
        wait_gnt(GNT_IFU_RD, n);
        wait_gnt(GNT_NONE, n);
        chk("err_rel", n, 4);
        cfg_rresp = OKAY;

        // reset in the middle of a 4-beat LSU read
        q_gnt.push_back(GNT_LSU_RD); q_gnt.push_back(GNT_NONE);
        lr_cnt = 0;
        q_lsu_req.push_back('{32'h8000_2000, 8'd3});
        step();
        wait_gnt(GNT_LSU_RD, n);
        cnt = 0;
        while (lr_cnt < 1 && cnt < 50) begin step(); cnt++; end
        chk("mid_beat", lr_cnt, 1);
        rst = 1;
        step();
        chk("mid_rst_gnt", grant_o, GNT_NONE);
        chk("mid_rst_outs", outs(), 12'd0);
        rst = 0;
        step();

        // both classes requesting back to back
`ifdef ARB_RR_EN
        for (int k = 0; k < 2; k++) begin
            q_gnt.push_back(GNT_IFU_RD); q_gnt.push_back(GNT_NONE); q_gnt.push_back(GNT_LSU_RD); q_gnt.push_back(GNT_NONE);
        end
`else
        for (int k = 0; k < 2; k++) begin q_gnt.push_back(GNT_LSU_RD); q_gnt.push_back(GNT_NONE); end
        for (int k = 0; k < 2; k++) begin q_gnt.push_back(GNT_IFU_RD); q_gnt.push_back(GNT_NONE); end
`endif
        for (int k = 0; k < 2; k++) begin
            q_ifu_req.push_back('{32'h3000_0400 + 32'(k * 16), 8'd1});
            q_lsu_req.push_back('{32'h8000_3000 + 32'(k * 16), 8'd0});
        end
        repeat (60) step();

        chk("left_gnt", q_gnt.size(), 0);
        chk("left_ifu_r", q_ifu_r.size(), 0);
        chk("left_lsu_r", q_lsu_r.size(), 0);
        chk("left_b", q_b.size() + q_wr.size(), 0);
        chk("end_gnt", grant_o, GNT_NONE);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/ysyx_23060221_axi_arbiter.md
YSYX_23060221_AXI_ARBITER -- requirements
Module: ysyx_23060221_axi_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning address width of all AR/AW channels.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data width of the R and W channels.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ifu_ar{valid,ready,addr,id,len,size,burst}  in/out  1/1/ADDR_W/4/8/3/2  IFU read-address channel (slave side).
REQ-006 SHALL have ifu_r{valid,ready,data,resp,last,id}  out/in  1/1/DATA_W/2/1/4  IFU read-data channel.
REQ-007 SHALL have lsu_ar* and lsu_r*  same widths as REQ-005/006  LSU read channels.
REQ-008 SHALL have lsu_aw{valid,ready,addr,id,len,size,burst}, lsu_w{valid,ready,data,strb,last}, lsu_b{valid,ready,resp,id}  AXI widths  LSU write channels.
REQ-009 SHALL have m_ar*, m_r*, m_aw*, m_w*, m_b*  mirror of the above  single downstream AXI master port.
REQ-010 SHALL have grant_o  output  2  current owner: 0 none, 1 IFU read, 2 LSU read, 3 LSU write.

Function
REQ-011 SHALL implement FSM states IDLE, RD_IFU, RD_LSU, WR_LSU; grant_o encodes the state.
REQ-012 SHALL arbitrate only in IDLE; requests are ifu_arvalid, lsu_arvalid, lsu_awvalid; grant is registered, so the owner's valid reaches m_* one cycle after the request is sampled.
REQ-013 SHALL use fixed priority lsu_aw > lsu_ar > ifu_ar when ARB_RR_EN is undefined.
REQ-014 SHALL, while granted, connect the owner's channels to m_* combinationally, both directions; non-owners see arready/awready/wready=0 and rvalid/bvalid=0.
REQ-015 SHALL drive m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready to 0 in IDLE and when the channel is not owned.
REQ-016 SHALL leave RD_* on the cycle m_rvalid & m_rready & m_rlast, returning to IDLE.
REQ-017 SHALL leave WR_LSU on the cycle m_bvalid & m_bready, returning to IDLE.
REQ-018 SHALL not arbitrate in the release cycle: a request pending at release is granted after one IDLE cycle (minimum one-cycle turnaround).
REQ-019 SHALL pass rresp/bresp unmodified, including SLVERR/DECERR; an error response does not change the release rule.
REQ-020 SHALL hold a grant indefinitely while the owner has not completed; there is no timeout.
REQ-021 SHALL ignore a requester withdrawing valid before grant (non-AXI behaviour, no state change).

Reset
REQ-022 SHALL, on rst, enter IDLE, set grant_o=0, clear the round-robin pointer to "IFU preferred", and drive every m_* valid/ready and every master-side ready/valid to 0.
REQ-023 SHALL, on rst mid-transaction, abandon the burst without waiting for rlast or bvalid.

Configuration
REQ-024 SHALL, with ARB_RR_EN defined, arbitrate IFU vs LSU (read or write) round-robin: when both request in IDLE, the class not granted last wins; within LSU, aw beats ar.
REQ-025 SHALL, with ARB_RR_EN undefined, use REQ-013 fixed priority and contain no pointer register.

Structure
REQ-026 SHALL place grant/state encodings (GNT_NONE, GNT_IFU_RD, GNT_LSU_RD, GNT_LSU_WR) and AXI resp constants (OKAY, SLVERR, DECERR) in a shared package ysyx_23060221_axi_pkg.
REQ-027 SHALL factor the IDLE-cycle request-to-winner selection into one combinational sub-module ysyx_23060221_arb_pick; muxing stays in the top.

Verification
REQ-028 SHALL cover: IFU ar addr 0x30000000 alone -> grant_o=1 next cycle, m_araddr=0x30000000, ifu_rdata returned, IDLE after rlast.
REQ-029 SHALL cover: ifu_arvalid and lsu_arvalid same cycle, ARB_RR_EN undefined -> LSU served first, IFU granted 1 cycle after LSU rlast.
REQ-030 SHALL cover: ARB_RR_EN defined, both request continuously -> grants alternate 1,2,1,2 with one IDLE cycle between.
REQ-031 SHALL cover: LSU write 0xDEADBEEF to 0x80001000, strb 0xF -> grant_o=3, IFU blocked with ifu_arready=0 until bvalid&bready.
REQ-032 SHALL cover: rresp=DECERR on IFU read -> ifu_rresp=2'b11, grant released normally.
REQ-033 SHALL cover: rst asserted during RD_LSU beat 2 of len=3 -> next cycle IDLE, grant_o=0, all valids 0.
